// File: rtl/game_flow_if.sv
// Signal bundle between game_flow_ctrl and the board/datapath side.
// master: the flow controller; slave: the environment that feeds it and consumes its outputs.
interface game_flow_if #(
    parameter int LIVES_W = 2,
    parameter int SERVE_W = 6
);
    logic               frame_tick;
    logic               start_btn;
    logic               pause_btn;
    logic               ball_lost;
    logic               run;
    logic               round_rst_n;
    logic               frame_tick_o;
    logic [LIVES_W-1:0] lives;
    logic [SERVE_W-1:0] serve_cnt;
    logic [2:0]         state;
    logic               game_over;

    modport master (
        input  frame_tick, start_btn, pause_btn, ball_lost,
        output run, round_rst_n, frame_tick_o, lives, serve_cnt, state, game_over
    );

    modport slave (
        output frame_tick, start_btn, pause_btn, ball_lost,
        input  run, round_rst_n, frame_tick_o, lives, serve_cnt, state, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Round/lives sequencer for the brick-breaker datapath: button debounce, serve countdown, lives, game over.
// Optional pause state is built when FLOW_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int LIVES        = 3,
    parameter int LIVES_W      = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int SERVE_W      = 6,
    parameter int RST_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    game_flow_if.master bus
);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SERVE_W-1:0] serve_q, serve_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic               run_q, run_d;
    logic               rrn_q, rrn_d;
    logic               over_q, over_d;

    logic start_sync_p0, start_sync_p1, start_smp, start_press;

    // Button synchronizers; the sample register only advances on frame boundaries
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_sync_p0 <= 1'b0;
            start_sync_p1 <= 1'b0;
            start_smp     <= 1'b0;
        end else begin
            start_sync_p0 <= bus.start_btn;
            start_sync_p1 <= start_sync_p0;
            if (bus.frame_tick)
                start_smp <= start_sync_p1;
        end
    end

    assign start_press = bus.frame_tick & start_sync_p1 & ~start_smp;

`ifdef FLOW_PAUSE_EN
    logic pause_sync_p0, pause_sync_p1, pause_smp, pause_press;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pause_sync_p0 <= 1'b0;
            pause_sync_p1 <= 1'b0;
            pause_smp     <= 1'b0;
        end else begin
            pause_sync_p0 <= bus.pause_btn;
            pause_sync_p1 <= pause_sync_p0;
            if (bus.frame_tick)
                pause_smp <= pause_sync_p1;
        end
    end

    assign pause_press = bus.frame_tick & pause_sync_p1 & ~pause_smp;
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        serve_d   = serve_q;
        rst_cnt_d = rst_cnt_q;

        case (state_q)
            IDLE: begin
                lives_d = LIVES_W'(LIVES);
                serve_d = '0;
                if (start_press) begin
                    state_d = SERVE;
                    serve_d = SERVE_W'(SERVE_FRAMES);
                end
            end
            SERVE: begin
                if (start_press) begin
                    state_d = PLAY;
                    serve_d = '0;
                end else if (bus.frame_tick) begin
                    if (serve_q <= SERVE_W'(1)) begin
                        state_d = PLAY;
                        serve_d = '0;
                    end else begin
                        serve_d = serve_q - SERVE_W'(1);
                    end
                end
            end
            PLAY: begin
                // A lost ball outranks a pause press in the same cycle
                if (bus.ball_lost) begin
                    state_d   = LOST;
                    rst_cnt_d = RST_W'(RST_CYCLES);
                    if (lives_q != '0)
                        lives_d = lives_q - LIVES_W'(1);
                end
`ifdef FLOW_PAUSE_EN
                else if (pause_press) begin
                    state_d = PAUSE;
                end
`endif
            end
            LOST: begin
                if (rst_cnt_q <= RST_W'(1)) begin
                    rst_cnt_d = '0;
                    if (lives_q == '0) begin
                        state_d = OVER;
                    end else begin
                        state_d = SERVE;
                        serve_d = SERVE_W'(SERVE_FRAMES);
                    end
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            OVER: begin
                if (start_press) begin
                    state_d = SERVE;
                    lives_d = LIVES_W'(LIVES);
                    serve_d = SERVE_W'(SERVE_FRAMES);
                end
            end
`ifdef FLOW_PAUSE_EN
            PAUSE: begin
                if (pause_press)
                    state_d = PLAY;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they move with it
        run_d  = (state_d == PLAY);
        rrn_d  = (state_d == SERVE) || (state_d == PLAY) || (state_d == PAUSE);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            lives_q   <= LIVES_W'(LIVES);
            serve_q   <= '0;
            rst_cnt_q <= '0;
            run_q     <= 1'b0;
            rrn_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            serve_q   <= serve_d;
            rst_cnt_q <= rst_cnt_d;
            run_q     <= run_d;
            rrn_q     <= rrn_d;
            over_q    <= over_d;
        end
    end

    assign bus.run          = run_q;
    assign bus.round_rst_n  = rrn_q;
    assign bus.game_over    = over_q;
    assign bus.lives        = lives_q;
    assign bus.serve_cnt    = serve_q;
    assign bus.state        = state_q;
    assign bus.frame_tick_o = bus.frame_tick & ((state_q == SERVE) || (state_q == PLAY));

endmodule
